// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one 4-bit combinational ALU between two requesters.
// Captures the winner's operands, holds them for EXEC_CYCLES, then returns the registered result.
module alu_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [7:0]       req_a,
   input  logic [7:0]       req_b,
   input  logic [5:0]       req_op,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [3:0]       rsp_data,
   output logic [2:0]       rsp_flags,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_op,
   input  logic [3:0]       alu_out,
   input  logic [2:0]       alu_flag,
   output logic             busy,
   output logic             grant_id,
   output logic [CNT_W-1:0] ops_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0] state;
   logic       prio;
   logic [3:0] settle;
   logic       winner;
   logic       handshake;

   // A lone requester always wins; the priority pointer only breaks ties.
   always_comb begin
      winner = prio;
      case (req_valid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         default: winner = prio;
      endcase
   end

   assign req_ready = ((state == S_IDLE) && (|req_valid)) ? (winner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid = (state == S_RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   assign handshake = (state == S_RESP) && rsp_ready[grant_id];
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         prio      <= 1'b0;
         settle    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         grant_id  <= 1'b0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         ops_done  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req_valid) begin
                  alu_a    <= winner ? req_a[7:4]  : req_a[3:0];
                  alu_b    <= winner ? req_b[7:4]  : req_b[3:0];
                  alu_op   <= winner ? req_op[5:3] : req_op[2:0];
                  grant_id <= winner;
                  settle   <= 4'(EXEC_CYCLES - 1);
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (settle == 4'd0) begin
                  rsp_data  <= alu_out;
                  rsp_flags <= alu_flag;
                  state     <= S_RESP;
               end else begin
                  settle <= settle - 4'd1;
               end
            end
            S_RESP: begin
               if (handshake) begin
                  ops_done <= ops_done + 1'b1;
                  prio     <= ~grant_id;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: three instances (EXEC_CYCLES = 1, 3, 4), each with a behavioural ALU.
module tb_alu_arbiter;

   logic       clk;
   logic       rst       [3];
   logic [1:0] req_valid [3];
   logic [1:0] req_ready [3];
   logic [7:0] req_a     [3];
   logic [7:0] req_b     [3];
   logic [5:0] req_op    [3];
   logic [1:0] rsp_valid [3];
   logic [1:0] rsp_ready [3];
   logic [3:0] rsp_data  [3];
   logic [2:0] rsp_flags [3];
   logic [3:0] alu_a     [3];
   logic [3:0] alu_b     [3];
   logic [2:0] alu_op    [3];
   logic [3:0] alu_out   [3];
   logic [2:0] alu_flag  [3];
   logic       busy      [3];
   logic       grant_id  [3];
   logic [7:0] ops_done  [3];

   int n_cmp  = 0;
   int n_fail = 0;

   // Stand-in for the shared ALU: returns {zero, overflow, carry, result}.
   function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic       ov;
      logic       c;
      s  = '0;
      ov = 1'b0;
      c  = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; ov = (a[3] == b[3]) && (r[3] != a[3]); end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; ov = (a[3] != b[3]) && (r[3] != a[3]); end
         3'd2: r = ~a;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = {3'b000, a < b};
         default: r = {3'b000, a == b};
      endcase
      return {(r == 4'd0), ov, c, r};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned E = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      assign {alu_flag[g], alu_out[g]} = alu_model(alu_a[g], alu_b[g], alu_op[g]);
      alu_arbiter #(.EXEC_CYCLES(E), .CNT_W(8)) dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_a     (req_a[g]),
         .req_b     (req_b[g]),
         .req_op    (req_op[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .rsp_flags (rsp_flags[g]),
         .alu_a     (alu_a[g]),
         .alu_b     (alu_b[g]),
         .alu_op    (alu_op[g]),
         .alu_out   (alu_out[g]),
         .alu_flag  (alu_flag[g]),
         .busy      (busy[g]),
         .grant_id  (grant_id[g]),
         .ops_done  (ops_done[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int d, input int r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      req_valid[d] = (r == 1) ? 2'b10 : 2'b01;
      req_a[d]     = (r == 1) ? {a, 4'h0} : {4'h0, a};
      req_b[d]     = (r == 1) ? {b, 4'h0} : {4'h0, b};
      req_op[d]    = (r == 1) ? {op, 3'b000} : {3'b000, op};
   endtask

   // Single requester transaction with the owner always ready; checks accept, latency, result, counter.
   task automatic run_txn(input int d, input int r, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input int exp_lat, input logic [3:0] ed,
                          input logic [2:0] ef, input string name);
      logic [7:0] prev;
      logic [1:0] oh;
      int         lat;
      oh = (r == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      prev = ops_done[d];
      set_req(d, r, a, b, op);
      rsp_ready[d] = oh;
      #1;
      chk({name, ".ready"}, 32'(req_ready[d]), 32'(oh));
      @(negedge clk);
      req_valid[d] = 2'b00;
      req_a[d]     = 8'hFF;
      lat = 1;
      while (rsp_valid[d] == 2'b00 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({name, ".rsp_valid"}, 32'(rsp_valid[d]), 32'(oh));
      chk({name, ".result"}, {25'd0, rsp_flags[d], rsp_data[d]}, {25'd0, ef, ed});
      chk({name, ".grant"}, 32'(grant_id[d]), 32'(r));
      @(negedge clk);
      chk({name, ".ops_done"}, 32'(ops_done[d]), 32'(8'(prev + 8'd1)));
      chk({name, ".idle"}, {30'd0, busy[d], |rsp_valid[d]}, 32'd0);
      rsp_ready[d] = 2'b00;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [3:0] d;
      logic [2:0] f;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int         lat;
      logic [3:0] held;
      logic [7:0] prev;

      vecs[0]  = '{4'h3, 4'h4, 3'd0, 4'h7, 3'b000};
      vecs[1]  = '{4'h7, 4'h1, 3'd0, 4'h8, 3'b010};
      vecs[2]  = '{4'hF, 4'h1, 3'd0, 4'h0, 3'b101};
      vecs[3]  = '{4'h5, 4'h3, 3'd1, 4'h2, 3'b000};
      vecs[4]  = '{4'h3, 4'h5, 3'd1, 4'hE, 3'b001};
      vecs[5]  = '{4'h5, 4'h0, 3'd2, 4'hA, 3'b000};
      vecs[6]  = '{4'hC, 4'hA, 3'd3, 4'h8, 3'b000};
      vecs[7]  = '{4'h5, 4'hA, 3'd4, 4'hF, 3'b000};
      vecs[8]  = '{4'hF, 4'hF, 3'd5, 4'h0, 3'b100};
      vecs[9]  = '{4'h3, 4'h5, 3'd6, 4'h1, 3'b000};
      vecs[10] = '{4'h5, 4'h5, 3'd7, 4'h1, 3'b000};
      vecs[11] = '{4'h5, 4'h4, 3'd7, 4'h0, 3'b100};

      for (int i = 0; i < 3; i++) begin
         rst[i]       = 1'b1;
         req_valid[i] = '0;
         req_a[i]     = '0;
         req_b[i]     = '0;
         req_op[i]    = '0;
         rsp_ready[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset%0d.outs", i),
             {req_ready[i], rsp_valid[i], rsp_data[i], rsp_flags[i], alu_a[i], alu_b[i], alu_op[i],
              busy[i], grant_id[i], ops_done[i]}, 32'd0);
         rst[i] = 1'b0;
      end

      for (int i = 0; i < 12; i++)
         run_txn(0, i % 2, vecs[i].a, vecs[i].b, vecs[i].op, 2, vecs[i].d, vecs[i].f, $sformatf("vec%0d", i));

      // Contention: pointer starts at requester 0 after reset, then alternates.
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0]       = 1'b0;
      req_valid[0] = 2'b11;
      req_a[0]     = 8'hFC;
      req_b[0]     = 8'h3A;
      req_op[0]    = 6'b011_011;
      rsp_ready[0] = 2'b11;
      for (int g = 0; g < 4; g++) begin
         lat = 0;
         while (rsp_valid[0] == 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("cont%0d.rsp_valid", g), 32'(rsp_valid[0]), (g % 2 == 1) ? 32'd2 : 32'd1);
         chk($sformatf("cont%0d.data", g), 32'(rsp_data[0]), (g % 2 == 1) ? 32'd3 : 32'd8);
         chk($sformatf("cont%0d.grant", g), 32'(grant_id[0]), 32'(g % 2));
         @(negedge clk);
      end
      req_valid[0] = 2'b00;
      rsp_ready[0] = 2'b00;
      repeat (3) @(negedge clk);

      // Backpressure on requester 1, with stray rsp_ready[0] pulses.
      prev = ops_done[0];
      set_req(0, 1, 4'h6, 4'h5, 3'd5);
      @(negedge clk);
      req_valid[0] = 2'b00;
      lat = 0;
      while (rsp_valid[0] == 2'b00 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      held = rsp_data[0];
      chk("bp.data", 32'(held), 32'h3);
      for (int k = 0; k < 5; k++) begin
         rsp_ready[0] = (k % 2 == 0) ? 2'b01 : 2'b00;
         @(negedge clk);
         chk($sformatf("bp%0d.hold", k), {22'd0, rsp_valid[0], rsp_data[0], ops_done[0]}, {22'd2, held, prev});
      end
      rsp_ready[0] = 2'b10;
      @(negedge clk);
      chk("bp.release", {22'd0, rsp_valid[0], ops_done[0]}, {22'd0, 8'(prev + 8'd1)});
      rsp_ready[0] = 2'b00;

      // Reset during EXEC on the 3-cycle instance.
      run_txn(1, 0, 4'h2, 4'h2, 3'd0, 4, 4'h4, 3'b000, "e3.first");
      @(negedge clk);
      set_req(1, 0, 4'h9, 4'h6, 3'd4);
      @(negedge clk);
      req_valid[1] = 2'b00;
      rst[1]       = 1'b1;
      @(negedge clk);
      chk("e3rst.state", {22'd0, busy[1], rsp_valid[1], alu_a[1], alu_b[1], alu_op[1]}, 32'd0);
      chk("e3rst.ops_done", 32'(ops_done[1]), 32'd0);
      rst[1]       = 1'b0;
      req_valid[1] = 2'b11;
      #1;
      chk("e3rst.regrant", 32'(req_ready[1]), 32'd1);
      @(negedge clk);
      req_valid[1] = 2'b00;
      repeat (4) @(negedge clk);
      chk("e3rst.dropped", 32'(ops_done[1]), 32'd0);

      // Settle length 4, then counter wrap.
      run_txn(2, 0, 4'h5, 4'h5, 3'd7, 5, 4'h1, 3'b000, "e4.eq");
      for (int n = 0; n < 254; n++)
         run_txn(2, n % 2, 4'h3, 4'h4, 3'd0, 5, 4'h7, 3'b000, $sformatf("wrap%0d", n));
      chk("wrap.full", 32'(ops_done[2]), 32'd255);
      run_txn(2, 1, 4'hF, 4'h1, 3'd0, 5, 4'h0, 3'b101, "wrap.last");
      chk("wrap.zero", 32'(ops_done[2]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
